banked_dmem: RTL
================

Name: banked_dmem

Overview:
- Parametrised data memory for the dual-issue MIPS pipeline, replacing the fixed two-port wrapper in the MEM stage.
- Serves NPORTS load/store ports, one per issue slot, over NBANKS word-interleaved single-ported banks.
- Adds byte-enable stores, valid/ready handshake with bank-conflict arbitration, registered 1-cycle read latency and a saturating conflict-stall counter.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 10, word-address width; total depth is 2**ADDR_W words.
- NPORTS, 2, number of access ports; port 0 is the oldest instruction in program order.
- NBANKS, 2, number of banks; power of two, not larger than 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NPORTS  per-port access request.
- req_ready  out  NPORTS  per-port grant (combinational); access is performed when valid&&ready.
- req_we  in  NPORTS  1 = store, 0 = load.
- req_be  in  NPORTS*DATA_W/8  byte enables per port; port p owns slice [p*DATA_W/8 +: DATA_W/8].
- req_addr  in  NPORTS*32  byte address per port.
- req_wdata  in  NPORTS*DATA_W  store data per port.
- rsp_valid  out  NPORTS  registered; load data valid for that port.
- rsp_rdata  out  NPORTS*DATA_W  registered load data.
- conflict_cnt  out  32  saturating count of cycles with at least one port denied.

Behaviour:
- Address decode:
  - word = addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 are ignored, so accesses wrap modulo depth.
  - bank = word mod NBANKS; row = word / NBANKS.
- Arbitration (combinational, same cycle):
  - Each bank accepts at most one access per cycle. Among valid ports targeting a bank, the lowest index wins.
  - req_ready[p] = 1 when p is the winner for its bank, or req_valid[p] = 0. A denied port sees ready = 0 and must hold all of its request fields stable.
  - No starvation handling: an older port always wins.
- Stores: at the granted edge, write only the bytes with be = 1. A store with be = 0 consumes the bank slot but leaves memory unchanged. Stores produce no response.
- Loads:
  - A load granted in cycle N gives rsp_valid[p] = 1 and rsp_rdata[p] = the full word in cycle N+1.
  - The returned value reflects all stores granted in cycles before N.
  - rsp_valid[p] is 0 in any cycle after a non-granted or store access. rsp_rdata holds its last value when rsp_valid = 0.
- Same-cycle hazards: two ports to the same word always collide on the same bank, so they serialise by port index. A store on port 0 followed by a load on port 1 to the same word therefore returns the new data one cycle later.
- conflict_cnt:
  - Increments by 1 on each edge where any port has req_valid = 1 and req_ready = 0.
  - Saturates at 32'hFFFF_FFFF.
- Reset (async, any time):
  - rsp_valid = 0, rsp_rdata = 0, conflict_cnt = 0.
  - An in-flight load response is discarded. A store granted in the reset cycle may be lost.
  - Memory contents are not cleared.
- Memory arrays are inferable as per-bank synchronous RAM with byte write enables.

Test Plan:
- Reset, then port0 store addr 0x0, be 4'hF, data 0xDEADBEEF; next cycle port0 load 0x0 -> rsp_valid[0] = 1 one cycle later with rsp_rdata = 0xDEADBEEF; conflict_cnt = 0.
- Byte enables: store 0x11223344 to 0x8 with be 4'b0101 over prior 0xAABBCCDD, then load 0x8 -> 0xAA22CC44.
- Bank conflict: same cycle, port0 store 0x10 = 0x5, port1 load 0x10 -> ready = 2'b01. Port1 holds; next cycle ready[1] = 1, and the cycle after rsp_rdata[1] = 0x5. conflict_cnt = 1.
- Parallel access: port0 load 0x0 (bank0), port1 load 0x4 (bank1), both valid -> ready = 2'b11, both rsp_valid next cycle, conflict_cnt unchanged.
- Wrap and alignment: store 0xCAFE0001 to 0x1000 (word 1024 ≡ 0 with ADDR_W = 10), then load 0x3 -> 0xCAFE0001.
- Reset mid-op: assert rst in the cycle after a granted load -> rsp_valid = 0 immediately and stays 0 after release. A previously stored word is still readable after reset.

Source files
------------

// File: rtl/banked_dmem.sv
// Banked data memory: NPORTS load/store ports over NBANKS word-interleaved single-ported banks.
// Latency: stores commit at the granted edge; load data is returned one cycle after grant.
// Backpressure: per-bank fixed priority (lowest port wins); a denied port sees req_ready=0 and holds.
module banked_dmem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int NPORTS = 2,
  parameter int NBANKS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NPORTS-1:0]          req_valid,
  output logic [NPORTS-1:0]          req_ready,
  input  logic [NPORTS-1:0]          req_we,
  input  logic [NPORTS*DATA_W/8-1:0] req_be,
  input  logic [NPORTS*32-1:0]       req_addr,
  input  logic [NPORTS*DATA_W-1:0]   req_wdata,
  output logic [NPORTS-1:0]          rsp_valid,
  output logic [NPORTS*DATA_W-1:0]   rsp_rdata,
  output logic [31:0]                conflict_cnt
);

  localparam int BE_W   = DATA_W / 8;
  localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int ROWS   = (2 ** ADDR_W) / NBANKS;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Per-port address decode
  logic [ADDR_W-1:0] port_word [NPORTS];
  logic [BANK_W-1:0] port_bank [NPORTS];
  logic [ROW_W-1:0]  port_row  [NPORTS];

  // Per-bank access selected by the arbiter
  logic [NBANKS-1:0] bank_en;
  logic [NBANKS-1:0] bank_we;
  logic [ROW_W-1:0]  bank_row   [NBANKS];
  logic [BE_W-1:0]   bank_be    [NBANKS];
  logic [DATA_W-1:0] bank_wdata [NBANKS];
  logic [DATA_W-1:0] bank_rd    [NBANKS];

  logic [NPORTS-1:0] grant;
  logic              conflict;

  // Response-side state
  logic [NPORTS-1:0] rsp_valid_d, rsp_valid_q;
  logic [BANK_W-1:0] rsp_bank_d [NPORTS];
  logic [BANK_W-1:0] rsp_bank_q [NPORTS];
  logic [DATA_W-1:0] hold_d     [NPORTS];
  logic [DATA_W-1:0] hold_q     [NPORTS];
  logic [31:0]       conflict_cnt_d, conflict_cnt_q;

  // Byte-offset bits and bits above the word range are ignored so accesses wrap modulo depth.
  logic unused_addr;
  assign unused_addr = ^req_addr;

  // Split each byte address into bank (low word bits) and row (remaining word bits).
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      port_word[p] = req_addr[p*32+2 +: ADDR_W];
      port_bank[p] = BANK_W'(port_word[p] % NBANKS);
      port_row[p]  = ROW_W'(port_word[p] / NBANKS);
    end
  end

  // Fixed-priority arbitration: walking ports in order, the first valid port to claim a bank wins it.
  always_comb begin
    logic [NBANKS-1:0] bank_busy;
    bank_busy = '0;
    grant     = '0;
    bank_en   = '0;
    bank_we   = '0;
    for (int b = 0; b < NBANKS; b++) begin
      bank_row[b]   = '0;
      bank_be[b]    = '0;
      bank_wdata[b] = '0;
    end
    for (int p = 0; p < NPORTS; p++) begin
      if (req_valid[p] && !bank_busy[port_bank[p]]) begin
        grant[p]                 = 1'b1;
        bank_busy[port_bank[p]]  = 1'b1;
        bank_en[port_bank[p]]    = 1'b1;
        bank_we[port_bank[p]]    = req_we[p];
        bank_row[port_bank[p]]   = port_row[p];
        bank_be[port_bank[p]]    = req_be[p*BE_W +: BE_W];
        bank_wdata[port_bank[p]] = req_wdata[p*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = grant | ~req_valid;
  assign conflict  = |(req_valid & ~req_ready);

  // One single-ported RAM per bank with byte write enables and a registered read port.
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem [ROWS];
    logic [DATA_W-1:0] ram_rd_q;

    // Write enabled bytes on a granted store; capture the addressed row on a granted load.
    always_ff @(posedge clk) begin
      if (bank_en[b]) begin
        if (bank_we[b]) begin
          for (int i = 0; i < BE_W; i++) begin
            if (bank_be[b][i]) begin
              mem[bank_row[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
            end
          end
        end else begin
          ram_rd_q <= mem[bank_row[b]];
        end
      end
    end

    assign bank_rd[b] = ram_rd_q;
  end

  // Route each port's response from the bank it loaded from, otherwise hold the last returned word.
  always_comb begin
    rsp_rdata = '0;
    for (int p = 0; p < NPORTS; p++) begin
      rsp_valid_d[p] = grant[p] & ~req_we[p];
      rsp_bank_d[p]  = port_bank[p];
      rsp_rdata[p*DATA_W +: DATA_W] = rsp_valid_q[p] ? bank_rd[rsp_bank_q[p]] : hold_q[p];
      hold_d[p]      = rsp_rdata[p*DATA_W +: DATA_W];
    end
  end

  // Saturating count of cycles in which any valid port was denied.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (conflict && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  // Response and counter registers; reset drops any in-flight load response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q    <= '0;
      conflict_cnt_q <= '0;
      for (int p = 0; p < NPORTS; p++) begin
        rsp_bank_q[p] <= '0;
        hold_q[p]     <= '0;
      end
    end else begin
      rsp_valid_q    <= rsp_valid_d;
      conflict_cnt_q <= conflict_cnt_d;
      for (int p = 0; p < NPORTS; p++) begin
        rsp_bank_q[p] <= rsp_bank_d[p];
        hold_q[p]     <= hold_d[p];
      end
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
